// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock: Q = A / B, R = A % B.
// A divisor of zero finishes immediately with Q = all-ones, R = A and a sticky flag.
module seq_restoring_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;

  // One restoring step: shift in the next dividend bit, trial-subtract at WIDTH+1 bits, restore on borrow
  always_comb begin
    remShift = {rem_q, quo_q[WIDTH-1]};
    trial    = remShift - {1'b0, dvs_q};
    if (trial[WIDTH] == 1'b0) begin
      remNext = trial[WIDTH-1:0];
    end else begin
      remNext = remShift[WIDTH-1:0];
    end
    quoNext = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Next-state logic: accept requests in IDLE/DONE, iterate in CALC, publish results on entering DONE
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (B != '0) begin
            quo_d   = A;
            dvs_d   = B;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            q_d     = '1;
            r_d     = A;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = remNext;
        quo_d = quoNext;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          q_d     = quoNext;
          r_d     = remNext;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table, scoreboard, multi-cycle corner cases.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t expQueue[$];
  exp_t monExp;
  vec_t vecs[13];
  int   checkCount = 0;
  int   passCount  = 0;

  seq_restoring_divider #(.WIDTH(8), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .A           (A),
    .B           (B),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic [7:0] q, input logic [7:0] r, input logic z);
    exp_t e;
    e.q   = q;
    e.r   = r;
    e.dbz = z;
    expQueue.push_back(e);
  endtask

  // Waits (bounded) for done, counting sampled cycles and busy cycles from the current negedge
  task automatic waitDone(output int lat, output int busyCnt);
    lat     = 0;
    busyCnt = int'(busy);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      busyCnt += int'(busy);
    end
    if (done !== 1'b1) checkOutput("doneTimeout", 32'(done), 32'd1);
  endtask

  // One full operation through IDLE: start, scramble operands, check latency, busy length and pulse width
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] q, input logic [7:0] r, input logic z);
    int lat;
    int busyCnt;
    int expLat;
    expLat = z ? 0 : 8;
    @(negedge clk);
    start = 1'b1;
    A     = a;
    B     = b;
    pushExp(q, r, z);
    @(negedge clk);
    start = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
    waitDone(lat, busyCnt);
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("busyCycles", 32'(busyCnt), 32'(expLat));
    @(negedge clk);
    checkOutput("donePulse", 32'(done), 32'd0);
  endtask

  // Scoreboard: every done must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      checkOutput("doneHasRequest", 32'(expQueue.size() != 0), 32'd1);
      if (expQueue.size() != 0) begin
        monExp = expQueue.pop_front();
        checkOutput("Q", 32'(Q), 32'(monExp.q));
        checkOutput("R", 32'(R), 32'(monExp.r));
        checkOutput("divByZero", 32'(div_by_zero), 32'(monExp.dbz));
      end
    end
  end

  initial begin
    int   lat;
    int   busyCnt;
    logic sawDone;
    logic [7:0] corner[8];
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2]  = '{8'd30,  8'd0,   8'hFF,  8'd30,  1'b1};
    vecs[3]  = '{8'd30,  8'd30,  8'd1,   8'd0,   1'b0};
    vecs[4]  = '{8'd128, 8'd129, 8'd0,   8'd128, 1'b0};
    vecs[5]  = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};
    vecs[6]  = '{8'd5,   8'd8,   8'd0,   8'd5,   1'b0};
    vecs[7]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[8]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[9]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[10] = '{8'd255, 8'd128, 8'd1,   8'd127, 1'b0};
    vecs[11] = '{8'd129, 8'd2,   8'd64,  8'd1,   1'b0};
    vecs[12] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};

    corner[0] = 8'd0;   corner[1] = 8'd1;   corner[2] = 8'd2;   corner[3] = 8'd127;
    corner[4] = 8'd128; corner[5] = 8'd129; corner[6] = 8'd254; corner[7] = 8'd255;

    rst_n = 1'b0;
    start = 1'b0;
    A     = 8'd0;
    B     = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("resetQ", 32'(Q), 32'd0);
    checkOutput("resetR", 32'(R), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetDbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    $display("[TB] back-to-back start in DONE");
    @(negedge clk);
    start = 1'b1; A = 8'd255; B = 8'd1;
    pushExp(8'd255, 8'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("b2bLatency1", 32'(lat), 32'd8);
    start = 1'b1; A = 8'd5; B = 8'd8;
    pushExp(8'd0, 8'd5, 1'b0);
    @(negedge clk);
    start = 1'b0; A = 8'd0; B = 8'd0;
    checkOutput("b2bNoIdle", 32'(busy), 32'd1);
    waitDone(lat, busyCnt);
    checkOutput("b2bLatency2", 32'(lat), 32'd8);
    @(negedge clk);

    $display("[TB] divide-by-zero hold and clear");
    applyStimulus(8'd30, 8'd0, 8'hFF, 8'd30, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("dbzHeld", 32'(div_by_zero), 32'd1);
    checkOutput("qHeldIdle", 32'(Q), 32'd255);
    checkOutput("rHeldIdle", 32'(R), 32'd30);
    start = 1'b1; A = 8'd30; B = 8'd30;
    pushExp(8'd1, 8'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("dbzClearedOnStart", 32'(div_by_zero), 32'd0);
    checkOutput("qHeldCalc", 32'(Q), 32'd255);
    waitDone(lat, busyCnt);
    checkOutput("dbzClearLatency", 32'(lat), 32'd8);
    @(negedge clk);

    $display("[TB] start ignored during CALC");
    start = 1'b1; A = 8'd200; B = 8'd3;
    pushExp(8'd66, 8'd2, 1'b0);
    @(negedge clk);
    start = 1'b0; A = 8'd1; B = 8'd2;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; A = 8'd9; B = 8'd9;
    @(negedge clk);
    start = 1'b0; A = 8'd77; B = 8'd0;
    waitDone(lat, busyCnt);
    checkOutput("ignoreLatency", 32'(lat), 32'd5);
    @(negedge clk);
    checkOutput("ignoreNoExtra", 32'(expQueue.size()), 32'd0);
    checkOutput("ignoreDoneLow", 32'(done), 32'd0);

    $display("[TB] reset mid-CALC");
    start = 1'b1; A = 8'd128; B = 8'd129;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("preResetBusy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midResetQ", 32'(Q), 32'd0);
    checkOutput("midResetR", 32'(R), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetDone", 32'(done), 32'd0);
    checkOutput("midResetDbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("noDoneAfterReset", 32'(sawDone), 32'd0);
    checkOutput("idleAfterReset", 32'(busy), 32'd0);
    applyStimulus(8'd128, 8'd129, 8'd0, 8'd128, 1'b0);

    $display("[TB] corner grid and random sweep");
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (corner[j] == 8'd0)
          applyStimulus(corner[i], corner[j], 8'hFF, corner[i], 1'b1);
        else
          applyStimulus(corner[i], corner[j], corner[i] / corner[j], corner[i] % corner[j], 1'b0);
      end
    end
    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0)
        applyStimulus(ra, rb, 8'hFF, ra, 1'b1);
      else
        applyStimulus(ra, rb, ra / rb, ra % rb, 1'b0);
    end

    @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
